// File: rtl/cp0_exc_unit_if.sv
// Memory-stage side of the coprocessor-0 exception unit: mfc0/mtc0/eret
// traffic, the trap inputs and the trap/redirect outputs.
interface cp0_exc_unit_if;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        we;
  logic [31:0] victim_pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic [31:0] rd_data;
  logic [31:0] epc_out;
  logic        int_req;
  logic [31:0] handler_pc;

  // Pipeline side: drives requests, observes trap decision and read data.
  modport master (
    output rd_addr, wr_addr, wr_data, we, victim_pc, bd, exc_code, hw_int, exl_clr,
    input  rd_data, epc_out, int_req, handler_pc
  );

  // CP0 side.
  modport slave (
    input  rd_addr, wr_addr, wr_data, we, victim_pc, bd, exc_code, hw_int, exl_clr,
    output rd_data, epc_out, int_req, handler_pc
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception unit: holds SR/Cause/EPC, decides when the
// pipeline must trap, and serves mfc0/mtc0/eret from the memory stage.
module cp0_exc_unit #(
  parameter logic [31:0] PRID    = 32'h4C58_4430,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic           clk,
  input  logic           reset,
  cp0_exc_unit_if.slave  bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC (bits [1:0] are always zero)
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic        int_req;
  logic [31:0] trap_epc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // Trap decision: masked interrupts or any pipelined exception, both blocked while EXL is set.
  always_comb begin
    int_pend = (|(bus.hw_int & im_q)) & ie_q & ~exl_q;
    exc_pend = (bus.exc_code != 5'd0) & ~exl_q;
    int_req  = int_pend | exc_pend;
    // A trapped delay-slot instruction restarts at its branch; wrap at address 0 is intended.
    if (bus.bd) begin
      trap_epc = (bus.victim_pc - 32'd4) & 32'hFFFF_FFFC;
    end else begin
      trap_epc = bus.victim_pc & 32'hFFFF_FFFC;
    end
  end

  // Next-state: trap beats eret, eret beats the EXL bit of a concurrent SR write.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = bus.hw_int;
    if (int_req) begin
      exl_d = 1'b1;
      bd_d  = bus.bd;
      epc_d = trap_epc;
      if (int_pend) begin
        exc_code_d = 5'd0;
      end else begin
        exc_code_d = bus.exc_code;
      end
    end else begin
      if (bus.we) begin
        case (bus.wr_addr)
          ADDR_SR: begin
            im_d  = bus.wr_data[15:10];
            exl_d = bus.wr_data[1];
            ie_d  = bus.wr_data[0];
          end
          ADDR_EPC: begin
            epc_d = {bus.wr_data[31:2], 2'b00};
          end
          default: begin
            // Cause, PRId and unmapped addresses are not software-writable.
          end
        endcase
      end else begin
        // No software write this cycle.
      end
      if (bus.exl_clr) begin
        exl_d = 1'b0;
      end else begin
        // EXL keeps whatever the write path decided.
      end
    end
  end

  // Architectural register state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Combinational mfc0 read port and redirect outputs; no write bypass.
  always_comb begin
    sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
    case (bus.rd_addr)
      ADDR_SR:    bus.rd_data = sr_val;
      ADDR_CAUSE: bus.rd_data = cause_val;
      ADDR_EPC:   bus.rd_data = epc_q;
      ADDR_PRID:  bus.rd_data = PRID;
      default:    bus.rd_data = 32'd0;
    endcase
    bus.epc_out    = epc_q;
    bus.int_req    = int_req;
    bus.handler_pc = HANDLER;
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit.
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID    = 32'h4C58_4430;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  cp0_exc_unit_if bus ();

  cp0_exc_unit #(.PRID(PRID), .HANDLER(HANDLER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Read a CP0 register through the mfc0 port and compare.
  task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.rd_addr = addr;
    #1;
    chk(tag, bus.rd_data, exp);
  endtask

  // Advance one rising edge and land just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we        = 1'b0;
    bus.wr_addr   = 5'd0;
    bus.wr_data   = 32'd0;
    bus.exc_code  = 5'd0;
    bus.bd        = 1'b0;
    bus.victim_pc = 32'd0;
    bus.exl_clr   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.rd_addr = 5'd0;
    bus.hw_int  = 6'd0;
    idle_inputs();

    // Reset state
    #2;
    rd_chk("rst_sr_held", 5'd12, 32'd0);
    chk("rst_intreq_held", {31'd0, bus.int_req}, 32'd0);
    #10;
    reset = 1'b1;
    tick();
    rd_chk("rst_sr", 5'd12, 32'd0);
    rd_chk("rst_cause", 5'd13, 32'd0);
    rd_chk("rst_epc", 5'd14, 32'd0);
    rd_chk("prid", 5'd15, PRID);
    rd_chk("unmapped_rd", 5'd3, 32'd0);
    chk("handler_pc", bus.handler_pc, HANDLER);
    chk("rst_intreq", {31'd0, bus.int_req}, 32'd0);

    // mtc0 SR, then an enabled interrupt traps in the same cycle
    bus.we = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h0000_FC01;
    bus.victim_pc = 32'h0000_0100;
    tick();
    bus.we = 1'b0;
    rd_chk("sr_write", 5'd12, 32'h0000_FC01);
    chk("no_int_idle", {31'd0, bus.int_req}, 32'd0);
    bus.hw_int = 6'b000100;
    #1;
    chk("int_same_cycle", {31'd0, bus.int_req}, 32'd1);
    tick();
    rd_chk("int_cause", 5'd13, 32'h0000_1000);
    rd_chk("int_sr_exl", 5'd12, 32'h0000_FC03);
    rd_chk("int_epc", 5'd14, 32'h0000_0100);
    chk("int_req_in_exl", {31'd0, bus.int_req}, 32'd0);

    // Nested exception ignored while EXL is set
    bus.exc_code = 5'd5; bus.victim_pc = 32'h0000_2000;
    #1;
    chk("nested_blocked", {31'd0, bus.int_req}, 32'd0);
    tick();
    rd_chk("nested_epc", 5'd14, 32'h0000_0100);
    rd_chk("nested_cause", 5'd13, 32'h0000_1000);
    chk("epc_out", bus.epc_out, 32'h0000_0100);

    // eret with the interrupt still asserted re-raises immediately
    bus.exc_code = 5'd0;
    bus.exl_clr  = 1'b1;
    tick();
    bus.exl_clr = 1'b0;
    rd_chk("eret_sr", 5'd12, 32'h0000_FC01);
    chk("eret_reraise", {31'd0, bus.int_req}, 32'd1);
    bus.hw_int = 6'd0;
    #1;
    chk("int_dropped", {31'd0, bus.int_req}, 32'd0);

    // Overflow exception
    bus.exc_code = 5'd12; bus.victim_pc = 32'h0000_3010; bus.bd = 1'b0;
    #1;
    chk("ov_req", {31'd0, bus.int_req}, 32'd1);
    tick();
    idle_inputs();
    rd_chk("ov_cause", 5'd13, 32'h0000_0030);
    rd_chk("ov_epc", 5'd14, 32'h0000_3010);
    rd_chk("ov_sr", 5'd12, 32'h0000_FC03);
    bus.exl_clr = 1'b1;
    tick();
    bus.exl_clr = 1'b0;

    // Interrupt beats an AdEL in a delay slot
    bus.exc_code = 5'd4; bus.bd = 1'b1; bus.victim_pc = 32'h0000_3024;
    bus.hw_int = 6'b000001;
    tick();
    idle_inputs();
    bus.hw_int = 6'd0;
    rd_chk("prio_cause", 5'd13, 32'h8000_0400);
    rd_chk("prio_epc", 5'd14, 32'h0000_3020);
    bus.exl_clr = 1'b1;
    tick();
    bus.exl_clr = 1'b0;
    rd_chk("prio_eret_cause", 5'd13, 32'h8000_0000);

    // Exception discards a same-cycle EPC write
    bus.exc_code = 5'd10; bus.victim_pc = 32'h0000_3000;
    bus.we = 1'b1; bus.wr_addr = 5'd14; bus.wr_data = 32'h0000_3457;
    tick();
    idle_inputs();
    rd_chk("trap_beats_we", 5'd14, 32'h0000_3000);
    rd_chk("ri_cause", 5'd13, 32'h0000_0028);
    // eret together with the EPC write: write lands
    bus.exl_clr = 1'b1;
    bus.we = 1'b1; bus.wr_addr = 5'd14; bus.wr_data = 32'h0000_3457;
    tick();
    idle_inputs();
    rd_chk("epc_write", 5'd14, 32'h0000_3454);
    rd_chk("eret_we_sr", 5'd12, 32'h0000_FC01);

    // Unlisted code recorded verbatim, EPC wrap from 0 in delay slot
    bus.exc_code = 5'd31; bus.bd = 1'b1; bus.victim_pc = 32'd0;
    tick();
    idle_inputs();
    rd_chk("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd_chk("wrap_cause", 5'd13, 32'h8000_007C);

    // eret wins over EXL bit of a concurrent SR write
    bus.exl_clr = 1'b1;
    bus.we = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h0000_0403;
    tick();
    idle_inputs();
    rd_chk("eret_vs_sr", 5'd12, 32'h0000_0401);

    // Read-only registers ignore writes
    bus.we = 1'b1; bus.wr_addr = 5'd13; bus.wr_data = 32'hFFFF_FFFF;
    tick();
    bus.wr_addr = 5'd15;
    tick();
    idle_inputs();
    rd_chk("cause_ro", 5'd13, 32'h8000_007C);
    rd_chk("prid_ro", 5'd15, PRID);
    rd_chk("sr_after_ro", 5'd12, 32'h0000_0401);

    // IE=0 masks interrupts
    bus.we = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h0000_FC00;
    tick();
    idle_inputs();
    bus.hw_int = 6'b111111;
    #1;
    chk("ie_mask", {31'd0, bus.int_req}, 32'd0);
    tick();
    bus.hw_int = 6'd0;
    rd_chk("ip_all", 5'd13, 32'h8000_FC7C);

    // Asynchronous reset in the middle of a trap
    bus.exc_code = 5'd5; bus.victim_pc = 32'h0000_5000;
    tick();
    idle_inputs();
    rd_chk("ades_sr", 5'd12, 32'h0000_FC02);
    reset = 1'b0;
    #1;
    chk("async_rst_sr", bus.rd_data, 32'd0);
    rd_chk("async_rst_epc", 5'd14, 32'd0);
    rd_chk("async_rst_cause", 5'd13, 32'd0);
    chk("async_rst_intreq", {31'd0, bus.int_req}, 32'd0);
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 block of the pipelined MIPS core.
- Receives the 5-bit exception codes from the execute-stage ALU and the other pipeline stages (4 = AdEL, 5 = AdES, 12 = Ov, 10 = RI) together with six hardware interrupt lines.
- Decides when to take a trap, records SR/Cause/EPC state, and serves mfc0/mtc0/eret from the memory stage.

Parameters:
- PRID, 32'h4C58_4430, read-only value returned for register 15.
- HANDLER, 32'h0000_4180, exception entry address driven on `handler_pc`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rd_addr`  in  5  mfc0 register select.
- `wr_addr`  in  5  mtc0 register select.
- `wr_data`  in  32  mtc0 write data.
- `we`  in  1  mtc0 write enable (memory stage).
- `victim_pc`  in  32  PC of the memory-stage instruction.
- `bd`  in  1  memory-stage instruction sits in a branch delay slot.
- `exc_code`  in  5  pipelined exception code; 0 = none.
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `exl_clr`  in  1  eret in memory stage.
- `rd_data`  out  32  mfc0 read data.
- `epc_out`  out  32  current EPC, for eret redirect.
- `int_req`  out  1  take trap this cycle; flush pipeline.
- `handler_pc`  out  32  equals HANDLER.

Behaviour:
- Registers and readable fields:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC (14): 32 bits, bits [1:0] always 0.
  - PRId (15): PRID.
  - Any other address reads 0; writes to it are ignored.
- Reset (`reset` = 0, asynchronous): SR = 0, Cause = 0, EPC = 0. Outputs follow: `rd_data` = 0 for addresses 12–14, `int_req` = 0.
- Interrupt condition: `int_pend` = |(hw_int & IM) & IE & !EXL.
- Exception condition: `exc_pend` = (exc_code != 0) & !EXL.
- `int_req` = `int_pend` | `exc_pend`. It is combinational: asserted in the same cycle as the inputs.
- `rd_data` and `epc_out` are combinational reads of the current register values. A same-cycle mtc0 is not bypassed.
- Rising edge, priority order, highest first:
  1. `int_req`:
     - EXL <= 1.
     - Cause.ExcCode <= 0 if `int_pend`, else `exc_code` (interrupt beats exception).
     - Cause.BD <= `bd`.
     - EPC <= (`bd` ? `victim_pc` - 4 : `victim_pc`) with bits [1:0] cleared.
     - A simultaneous `we` or `exl_clr` is discarded.
  2. `exl_clr` (no `int_req`): EXL <= 0. A simultaneous `we` still applies to other fields. If `we` targets SR, the written EXL loses to the clear.
  3. `we`:
     - SR: IM <= `wr_data`[15:10], EXL <= `wr_data`[1], IE <= `wr_data`[0].
     - EPC: EPC <= {`wr_data`[31:2], 2'b00}.
     - Cause and PRId are read-only to software.
- Cause.IP <= `hw_int` on every edge regardless of the other events, including during EXL.
- While EXL = 1:
  - `int_req` is held at 0.
  - Nested exceptions and interrupts are ignored; no register changes except IP and software writes.
- `victim_pc` = 0 with `bd` = 1 wraps to EPC = 32'hFFFF_FFFC. This is accepted, not trapped.
- `exc_code` values outside {4, 5, 10, 12} are still recorded verbatim.

Test Plan:
- Reset then release → `rd_data`(12) = 0, `rd_data`(13) = 0x0000_0000, `int_req` = 0. Also assert `reset` mid-trap with EXL = 1 → EXL reads 0 immediately, without waiting for an edge.
- mtc0 SR = 0x0000_FC01, `hw_int` = 6'b000100 → `int_req` = 1 the same cycle. After the edge: `rd_data`(13) = 0x0000_1000, SR = 0x0000_FC03, `int_req` = 0.
- `exc_code` = 12, `victim_pc` = 0x0000_3010, `bd` = 0 → `int_req` = 1. After the edge: Cause[6:2] = 12, EPC = 0x0000_3010, BD = 0.
- `exc_code` = 4, `bd` = 1, `victim_pc` = 0x0000_3024, with `hw_int`[0] = 1 enabled → interrupt wins. Cause.ExcCode = 0, BD = 1, EPC = 0x0000_3020.
- With EXL = 1, apply `exc_code` = 5 → `int_req` = 0 and EPC unchanged. Then `exl_clr` → EXL = 0 next cycle, and a pending IE/IM interrupt raises `int_req` immediately.
- Same cycle: `we` to EPC with 0x0000_3457 plus an exception at `victim_pc` = 0x0000_3000 → EPC = 0x0000_3000. Without the exception, the same write gives EPC = 0x0000_3454.
